// File: rtl/mux_serial_sequencer_pkg.sv
// Purpose: shared state encoding, default widths and select start values for the bit-serial sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_serial_sequencer_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int SEL_W_DEF  = 5;

    localparam logic [SEL_W_DEF-1:0] SEL_MSB = 5'd31;
    localparam logic [SEL_W_DEF-1:0] SEL_LSB = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/mux_sel_stepper.sv
// Purpose: mux select register plus beat counter; load sets the start select, step walks it by one.
// Latency: select/count update one cycle after load_i or step_i.
// Backpressure: holds select and count whenever step_i is low; never steps past the terminal beat.
module mux_sel_stepper
    import mux_serial_sequencer_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             dir_i,
    input  logic [SEL_W-1:0] len_i,
    output logic [SEL_W-1:0] sel_o,
    output logic [SEL_W-1:0] cnt_o,
    output logic             term_o
);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] len_q, len_d;

    assign term_o = (cnt_q == len_q);
    assign sel_o  = sel_q;
    assign cnt_o  = cnt_q;

    // Next select/count: load restarts at the end chosen by direction; step advances until terminal.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            sel_d = dir_i ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
            cnt_d = '0;
            len_d = len_i;
        end else if (step_i && !term_o) begin
            sel_d = dir_i ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
            cnt_d = cnt_q + SEL_W'(1);
        end
    end

    // Select, counter and captured length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/mux_serial_sequencer.sv
// Purpose: captures a word and serializes len+1 bits through the external 32:1 mux (SER_PARITY_EN adds an even-parity beat).
// Latency: first serial beat valid one cycle after word acceptance; one idle cycle between words.
// Backpressure: ser_ready low freezes select, count, word and serial outputs; in_ready low outside IDLE.
module mux_serial_sequencer
    import mux_serial_sequencer_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [SEL_W-1:0]  in_len,
    output logic [WORD_W-1:0] word_q,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_bit,
    output logic              ser_last,
    output logic              busy
);

    state_e           state_q, state_d;
    logic             load;
    logic             step;
    logic             term;
    logic [SEL_W-1:0] cnt;

`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    mux_sel_stepper #(
        .SEL_W (SEL_W)
    ) u_stepper (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .dir_i  (MSB_FIRST != 0),
        .len_i  (in_len),
        .sel_o  (mux_sel),
        .cnt_o  (cnt),
        .term_o (term)
    );

    assign busy = (state_q != ST_IDLE);

    // Next-state and handshake outputs; data beats show the mux output directly.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_last  = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                ser_valid = 1'b1;
                ser_bit   = mux_bit;
`ifdef SER_PARITY_EN
                ser_last  = 1'b0;
`else
                ser_last  = term;
`endif
                if (ser_ready) begin
                    step = 1'b1;
                    if (term) begin
`ifdef SER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_bit   = par_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register feeding the mux inputs; only written on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= in_word;
        end
    end

`ifdef SER_PARITY_EN
    // Running even parity over every bit actually handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= 1'b0;
        end else if (state_q == ST_SEND && ser_ready) begin
            par_q <= par_q ^ mux_bit;
        end
    end
`endif

    // Count is only consumed through the terminal flag here.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_mux_serial_sequencer.sv
module tb_mux_serial_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_word;
    logic [4:0]  in_len;
    logic        ser_ready;

    logic        in_ready_m, in_ready_l;
    logic [31:0] word_q_m, word_q_l;
    logic [4:0]  mux_sel_m, mux_sel_l;
    logic        mux_bit_m, mux_bit_l;
    logic        ser_valid_m, ser_valid_l;
    logic        ser_bit_m, ser_bit_l;
    logic        ser_last_m, ser_last_l;
    logic        busy_m, busy_l;

    int tests = 0;
    int fails = 0;

    // External 32:1 muxes
    assign mux_bit_m = word_q_m[mux_sel_m];
    assign mux_bit_l = word_q_l[mux_sel_l];

    mux_serial_sequencer #(.WORD_W(32), .SEL_W(5), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_word(in_word), .in_len(in_len), .word_q(word_q_m), .mux_sel(mux_sel_m),
        .mux_bit(mux_bit_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
        .ser_bit(ser_bit_m), .ser_last(ser_last_m), .busy(busy_m)
    );

    mux_serial_sequencer #(.WORD_W(32), .SEL_W(5), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_word(in_word), .in_len(in_len), .word_q(word_q_l), .mux_sel(mux_sel_l),
        .mux_bit(mux_bit_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
        .ser_bit(ser_bit_l), .ser_last(ser_last_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  len;
        bit          tgl;     // ser_ready alternates 1/0 each cycle
        logic [31:0] exp_m;   // bit i = expected beat i, MSB-first instance
        logic [31:0] exp_l;   // bit i = expected beat i, LSB-first instance
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int beat;
        int cyc;
        logic [32:0] mask;
        mask = (33'd1 << (int'(v.len) + 1)) - 33'd1;
        chk($sformatf("v%0d idle in_ready", idx), int'(in_ready_m), 1);
        in_word  = v.word;
        in_len   = v.len;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = ~v.word;
        in_len   = ~v.len;
        chk($sformatf("v%0d busy after accept", idx), int'(busy_m), 1);
        chk($sformatf("v%0d in_ready low in send", idx), int'(in_ready_l), 0);
        beat = 0;
        cyc  = 0;
        while (beat <= int'(v.len) && cyc < 200) begin
            ser_ready = v.tgl ? ((cyc % 2) == 0) : 1'b1;
            #1;
            chk($sformatf("v%0d b%0d valid_m", idx, beat), int'(ser_valid_m), 1);
            chk($sformatf("v%0d b%0d bit_m", idx, beat), int'(ser_bit_m), int'(v.exp_m[beat]));
            chk($sformatf("v%0d b%0d sel_m", idx, beat), int'(mux_sel_m), 31 - beat);
            chk($sformatf("v%0d b%0d bit_l", idx, beat), int'(ser_bit_l), int'(v.exp_l[beat]));
            chk($sformatf("v%0d b%0d sel_l", idx, beat), int'(mux_sel_l), beat);
`ifdef SER_PARITY_EN
            chk($sformatf("v%0d b%0d last_m", idx, beat), int'(ser_last_m), 0);
`else
            chk($sformatf("v%0d b%0d last_m", idx, beat), int'(ser_last_m), int'(beat == int'(v.len)));
            chk($sformatf("v%0d b%0d last_l", idx, beat), int'(ser_last_l), int'(beat == int'(v.len)));
`endif
            if (ser_ready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 200) chk($sformatf("v%0d beat timeout", idx), beat, int'(v.len) + 1);
`ifdef SER_PARITY_EN
        ser_ready = 1'b1;
        #1;
        chk($sformatf("v%0d parity valid", idx), int'(ser_valid_m), 1);
        chk($sformatf("v%0d parity last", idx), int'(ser_last_m), 1);
        chk($sformatf("v%0d parity bit_m", idx), int'(ser_bit_m), int'(^(v.exp_m & mask[31:0])));
        chk($sformatf("v%0d parity bit_l", idx), int'(ser_bit_l), int'(^(v.exp_l & mask[31:0])));
        @(posedge clk); #1;
`endif
        ser_ready = 1'b0;
        chk($sformatf("v%0d in_ready after", idx), int'(in_ready_m), 1);
        chk($sformatf("v%0d busy_l after", idx), int'(busy_l), 0);
        chk($sformatf("v%0d valid after", idx), int'(ser_valid_m), 0);
        chk($sformatf("v%0d final sel_m", idx), int'(mux_sel_m), 31 - int'(v.len));
        chk($sformatf("v%0d final sel_l", idx), int'(mux_sel_l), int'(v.len));
    endtask

    initial begin
        vecs[0] = '{word: 32'hA500_0000, len: 5'd7,  tgl: 1'b0, exp_m: 32'h0000_00A5, exp_l: 32'h0000_0000};
        vecs[1] = '{word: 32'h0000_000D, len: 5'd3,  tgl: 1'b0, exp_m: 32'h0000_0000, exp_l: 32'h0000_000D};
        vecs[2] = '{word: 32'hFFFF_0000, len: 5'd31, tgl: 1'b1, exp_m: 32'h0000_FFFF, exp_l: 32'hFFFF_0000};
        vecs[3] = '{word: 32'h8000_0000, len: 5'd0,  tgl: 1'b0, exp_m: 32'h0000_0001, exp_l: 32'h0000_0000};
        vecs[4] = '{word: 32'hE000_0000, len: 5'd3,  tgl: 1'b0, exp_m: 32'h0000_0007, exp_l: 32'h0000_0000};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_len    = '0;
        ser_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", int'(busy_m), 0);
        chk("reset ser_valid", int'(ser_valid_m), 0);
        chk("reset ser_last", int'(ser_last_m), 0);
        chk("reset mux_sel", int'(mux_sel_m), 0);
        chk("reset word_q", int'(word_q_m), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", int'(in_ready_m), 1);
        chk("post-reset ser_valid", int'(ser_valid_l), 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Abort a 16-bit send during its 5th beat
        in_word  = 32'h1234_5678;
        in_len   = 5'd15;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort pre valid", int'(ser_valid_m), 1);
        chk("abort pre sel", int'(mux_sel_m), 27);
        rst_n = 1'b0;
        #1;
        chk("abort ser_valid", int'(ser_valid_m), 0);
        chk("abort busy", int'(busy_m), 0);
        chk("abort ser_last", int'(ser_last_l), 0);
        chk("abort mux_sel", int'(mux_sel_m), 0);
        chk("abort word_q", int'(word_q_m), 0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort idle%0d in_ready", c), int'(in_ready_m), 1);
            chk($sformatf("abort idle%0d ser_valid", c), int'(ser_valid_m), 0);
            chk($sformatf("abort idle%0d busy", c), int'(busy_l), 0);
        end
        ser_ready = 1'b0;
        run_vec(5, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
